// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its pending-write scoreboard.
// Holds default widths, register index/data typedefs and a helper for
// locating port k inside the packed multi-port address/data buses.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Lowest bit of port k in a bus packed as k*w +: w.
  function automatic int unsigned port_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file.
// Tracks which registers have an issued but not yet written-back producer,
// the number of such registers, a sticky error for writebacks that had no
// producer, and per-read-port busy flags (combinational).
// Ports:
//   clk, rst            clock, async active-high reset
//   rd_addr             packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   wr_en, wr_addr      writeback (clears pending)
//   iss_en, iss_addr    issue with destination (sets pending)
//   rd_busy_c           per-port hazard flag, combinational
//   pend_cnt            number of pending registers (registered)
//   sb_err              sticky spurious-writeback flag (registered)
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy_c,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     sb_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             sb_err_q, sb_err_d;
  logic             set_vld, clr_vld, inc, dec;

  // Pending bit, count and error next-state.
  always_comb begin
    set_vld    = iss_en && !(ZERO_REG && (iss_addr == '0));
    clr_vld    = wr_en && !(ZERO_REG && (wr_addr == '0));
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    sb_err_d   = sb_err_q;

    // Set applied after clear so a same-register collision keeps the new producer.
    if (clr_vld) pend_d[wr_addr] = 1'b0;
    if (set_vld) pend_d[iss_addr] = 1'b1;

    inc = set_vld && !pend_q[iss_addr];
    dec = clr_vld && pend_q[wr_addr] && !(set_vld && (iss_addr == wr_addr));

    if (inc && !dec && (pend_cnt_q != CNT_MAX)) begin
      pend_cnt_d = pend_cnt_q + CNT_W'(1);
    end else if (dec && !inc && (pend_cnt_q != '0)) begin
      pend_cnt_d = pend_cnt_q - CNT_W'(1);
    end

    if (clr_vld && !pend_q[wr_addr]) sb_err_d = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      sb_err_q   <= sb_err_d;
    end
  end

  // A same-cycle writeback to the source is bypassed, so it is not a hazard.
  always_comb begin
    rd_busy_c = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_busy_c[k] = pend_q[rd_addr[port_lo(k, ADDR_W) +: ADDR_W]] &&
                     !(wr_en && (wr_addr == rd_addr[port_lo(k, ADDR_W) +: ADDR_W]));
    end
  end

  assign pend_cnt = pend_cnt_q;
  assign sb_err   = sb_err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file for the pipelined MIPS datapath with
// combinational read ports, write-to-read bypass, one posedge write port
// and an integrated pending-write scoreboard for RAW hazard detection.
// Optional build macro: REGFILE_INDEX_INIT_EN -- reset loads mem[i] = i
// (register 0 still 0); without it reset loads zeros.
// Ports:
//   clk, rst            clock, async active-high reset (priority)
//   rd_addr / rd_data   NUM_RD packed read ports (combinational)
//   rd_busy             per-port source-pending flag (combinational)
//   wr_en/addr/data     writeback port
//   iss_en/addr         issued destination
//   pend_cnt            registers currently pending
//   sb_err              sticky writeback-without-producer flag
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     sb_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic                     wr_ok_c;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Writes to register 0 are dropped when it is hardwired.
  always_comb begin
    wr_ok_c = wr_en && !(ZERO_REG && (wr_addr == '0));
    mem_d   = mem_q;
    if (wr_ok_c) mem_d[wr_addr] = wr_data;
  end

  // Storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef REGFILE_INDEX_INIT_EN
        mem_q[i] <= DATA_W'(i);
`else
        mem_q[i] <= '0;
`endif
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes: bypass, then hardwired zero, then storage.
  // Bypass is blocked during reset so reads show the reset contents.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (wr_ok_c && !rst && (wr_addr == rd_addr[port_lo(k, ADDR_W) +: ADDR_W])) begin
        rd_data_c[port_lo(k, DATA_W) +: DATA_W] = wr_data;
      end else if (ZERO_REG && (rd_addr[port_lo(k, ADDR_W) +: ADDR_W] == '0)) begin
        rd_data_c[port_lo(k, DATA_W) +: DATA_W] = '0;
      end else begin
        rd_data_c[port_lo(k, DATA_W) +: DATA_W] = mem_q[rd_addr[port_lo(k, ADDR_W) +: ADDR_W]];
      end
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .rd_busy_c (rd_busy_c),
    .pend_cnt  (pend_cnt),
    .sb_err    (sb_err)
  );

  assign rd_data = rd_data_c;
  assign rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters).
// Vectors are driven just after posedge; expected outputs are queued at
// drive time and popped/compared at the following negedge.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

`ifdef REGFILE_INDEX_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  reg_idx_t   ra0, ra1;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic       wr_en;
  reg_idx_t   wr_addr;
  reg_data_t  wr_data;
  logic       iss_en;
  reg_idx_t   iss_addr;
  logic [5:0] pend_cnt;
  logic       sb_err;

  assign rd_addr = {ra1, ra0};

  regfile_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_cnt (pend_cnt),
    .sb_err   (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    reg_idx_t   wa;
    reg_data_t  wd;
    logic       ie;
    reg_idx_t   ia;
    reg_idx_t   r0;
    reg_idx_t   r1;
    reg_data_t  d0;
    reg_data_t  d1;
    logic [1:0] busy;
    logic [5:0] cnt;
    logic       err;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   chk_idx = 0;
  vec_t q[$];
  vec_t vecs[18];
  vec_t e;

  // Reset-time contents of register i.
  function automatic reg_data_t iv(input int i);
    return INIT_EN ? 32'(i) : 32'd0;
  endfunction

  function automatic vec_t mk(input logic we, input int wa, input reg_data_t wd,
                              input logic ie, input int ia, input int r0, input int r1,
                              input reg_data_t d0, input reg_data_t d1,
                              input logic [1:0] busy, input int cnt, input logic err);
    vec_t v;
    v.we = we; v.wa = 5'(wa); v.wd = wd; v.ie = ie; v.ia = 5'(ia);
    v.r0 = 5'(r0); v.r1 = 5'(r1); v.d0 = d0; v.d1 = d1;
    v.busy = busy; v.cnt = 6'(cnt); v.err = err;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    iss_en = v.ie; iss_addr = v.ia;
    ra0 = v.r0; ra1 = v.r1;
    q.push_back(v);
  endtask

  // Scoreboard check: one queued expectation per cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp($sformatf("v%0d_d0", chk_idx), rd_data[31:0], e.d0);
      cmp($sformatf("v%0d_d1", chk_idx), rd_data[63:32], e.d1);
      cmp($sformatf("v%0d_busy", chk_idx), 32'(rd_busy), 32'(e.busy));
      cmp($sformatf("v%0d_cnt", chk_idx), 32'(pend_cnt), 32'(e.cnt));
      cmp($sformatf("v%0d_err", chk_idx), 32'(sb_err), 32'(e.err));
      chk_idx++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we wa  wd            ie ia  r0  r1  d0             d1             busy   cnt err
    vecs[0]  = mk(0, 0,  32'h0,        0, 0,  7,  31, iv(7),         iv(31),        2'b00, 0, 0);
    vecs[1]  = mk(0, 0,  32'h0,        1, 5,  5,  0,  iv(5),         32'h0,         2'b00, 0, 0);
    vecs[2]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  5,  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 1, 0);
    vecs[3]  = mk(0, 0,  32'h0,        0, 0,  5,  0,  32'hDEADBEEF,  32'h0,         2'b00, 0, 0);
    vecs[4]  = mk(1, 0,  32'h1234,     1, 0,  0,  5,  32'h0,         32'hDEADBEEF,  2'b00, 0, 0);
    vecs[5]  = mk(0, 0,  32'h0,        1, 3,  0,  3,  32'h0,         iv(3),         2'b00, 0, 0);
    vecs[6]  = mk(0, 0,  32'h0,        0, 0,  3,  5,  iv(3),         32'hDEADBEEF,  2'b01, 1, 0);
    vecs[7]  = mk(1, 3,  32'h55,       0, 0,  3,  3,  32'h55,        32'h55,        2'b00, 1, 0);
    vecs[8]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h55,        32'h0,         2'b00, 0, 0);
    vecs[9]  = mk(0, 0,  32'h0,        1, 9,  9,  4,  iv(9),         iv(4),         2'b00, 0, 0);
    vecs[10] = mk(1, 9,  32'h99,       1, 9,  9,  4,  32'h99,        iv(4),         2'b00, 1, 0);
    vecs[11] = mk(0, 0,  32'h0,        0, 0,  9,  4,  32'h99,        iv(4),         2'b01, 1, 0);
    vecs[12] = mk(1, 9,  32'h9A,       1, 4,  4,  9,  iv(4),         32'h9A,        2'b00, 1, 0);
    vecs[13] = mk(0, 0,  32'h0,        0, 0,  4,  9,  iv(4),         32'h9A,        2'b01, 1, 0);
    vecs[14] = mk(1, 4,  32'h44,       0, 0,  4,  4,  32'h44,        32'h44,        2'b00, 1, 0);
    vecs[15] = mk(0, 0,  32'h0,        0, 0,  4,  9,  32'h44,        32'h9A,        2'b00, 0, 0);
    vecs[16] = mk(1, 12, 32'hC0C0,     0, 0,  12, 0,  32'hC0C0,      32'h0,         2'b00, 0, 0);
    vecs[17] = mk(0, 0,  32'h0,        0, 0,  12, 0,  32'hC0C0,      32'h0,         2'b00, 0, 1);

    // Reset state, observed while rst is still high.
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; ra0 = 5'd7; ra1 = 5'd31;
    #2;
    cmp("rst_d0", rd_data[31:0], iv(7));
    cmp("rst_d1", rd_data[63:32], iv(31));
    cmp("rst_busy", 32'(rd_busy), 32'd0);
    cmp("rst_cnt", 32'(pend_cnt), 32'd0);
    cmp("rst_err", 32'(sb_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) apply(vecs[i]);

    // sb_err stays set while idle.
    for (int i = 0; i < 10; i++)
      apply(mk(0, 0, 32'h0, 0, 0, 12, 0, 32'hC0C0, 32'h0, 2'b00, 0, 1));

    // Reset clears the sticky error.
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    cmp("err_rst_err", 32'(sb_err), 32'd0);
    cmp("err_rst_d0", rd_data[31:0], iv(12));
    #1;
    rst = 1'b0;

    // Async reset in the middle of a cycle with three pending registers.
    apply(mk(0, 0, 32'h0, 1, 1, 1, 3, iv(1), iv(3), 2'b00, 0, 0));
    apply(mk(0, 0, 32'h0, 1, 2, 1, 3, iv(1), iv(3), 2'b01, 1, 0));
    apply(mk(0, 0, 32'h0, 1, 3, 1, 3, iv(1), iv(3), 2'b01, 2, 0));
    apply(mk(0, 0, 32'h0, 0, 0, 1, 3, iv(1), iv(3), 2'b11, 3, 0));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    cmp("async_cnt", 32'(pend_cnt), 32'd0);
    cmp("async_busy", 32'(rd_busy), 32'd0);
    cmp("async_err", 32'(sb_err), 32'd0);
    cmp("async_d0", rd_data[31:0], iv(1));
    cmp("async_d1", rd_data[63:32], iv(3));
    #1;
    rst = 1'b0;

    // A late writeback after the flush is spurious.
    apply(mk(1, 2, 32'h22, 0, 0, 2, 1, 32'h22, iv(1), 2'b00, 0, 0));
    apply(mk(0, 0, 32'h0, 0, 0, 2, 1, 32'h22, iv(1), 2'b00, 0, 1));

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    cmp("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
